clk_freq_monitor: RTL and testbench
===================================

// Module: clk_freq_monitor
// PURPOSE
//  Measures the period of a slow clock, in clk200M_in cycles, produced by the local clock divider (default: the 470 kHz output).
//  Declares lock after LOCK_CNT consecutive in-tolerance periods.
//  Raises a sticky fault on an out-of-range period or a stalled clock; the NICE/PE control path uses it to qualify the divided clock.
// PARAMETERS
//  CNT_W     12   width of period counter / period_o
//  EXP_PER   426  expected period in clk200M_in cycles (2*213)
//  TOL       4    allowed deviation; good iff EXP_PER-TOL <= period <= EXP_PER+TOL
//  LOCK_CNT  4    consecutive good periods needed to lock
//  TIMEOUT   1023 cycles without a rising edge -> stall fault; require EXP_PER+TOL < TIMEOUT < 2**CNT_W
// PORTS
//  clk200M_in    in   1      system clock, 200 MHz
//  rst_n         in   1      asynchronous, active-low reset
//  en            in   1      monitor enable (level)
//  clr           in   1      1-cycle pulse; clears fault and re-arms
//  mon_clk_in    in   1      monitored clock, asynchronous to clk200M_in
//  period_o      out  CNT_W  last measured period
//  period_vld_o  out  1      1-cycle pulse when period_o updates
//  locked_o      out  1      frequency locked
//  fault_o       out  1      sticky fault flag
//  fault_code_o  out  2      00 none, 01 too short, 10 too long, 11 stall
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, cnt=0, good_cnt=0, synchronizer flops 0.
//  Sync: mon_clk_in -> 2-FF synchronizer (s1,s2) -> s3; rise = s2 & ~s3.
//   Latency from mon_clk_in edge to rise is 2-3 cycles.
//  Counter cnt (CNT_W): in IDLE held 0.
//   Otherwise: rise -> cnt<=0; else cnt<=cnt+1, saturating at all-ones.
//   Measured period = cnt+1 at rise, so an ideal 426-cycle clock gives 426.
//  States IDLE, ARM, ACQ, LOCKED, FAULT. Priority each cycle: en=0 > clr > rise > stall.
//  en=0 in any state -> IDLE next cycle; clears locked_o, fault_o, fault_code_o and good_cnt; period_o holds.
//  IDLE: en=1 -> ARM.
//  ARM: no measurement. rise -> ACQ with good_cnt=0. cnt==TIMEOUT without rise -> FAULT, code 11.
//  ACQ: on rise, period_o<=cnt+1 and pulse period_vld_o.
//   Good -> good_cnt+1; if the new value == LOCK_CNT -> LOCKED, locked_o=1.
//   Bad -> good_cnt=0, stay ACQ, no fault.
//   Stall (cnt==TIMEOUT, no rise) -> FAULT, code 11.
//  LOCKED: on rise, update period_o and pulse period_vld_o.
//   Good -> stay.
//   Short (< EXP_PER-TOL) -> FAULT, code 01. Long (> EXP_PER+TOL) -> FAULT, code 10.
//   Stall -> FAULT, code 11.
//  FAULT: fault_o=1 and locked_o=0 on entry (registered with the transition).
//   Code frozen until clr or en=0. Rises still update period_o and pulse period_vld_o.
//   clr -> ARM, fault_o/fault_code_o cleared, good_cnt=0.
//  Rise and stall in the same cycle: the rise wins, and the period is evaluated as long if out of range.
//  clr outside FAULT: ignored.
//  Reset mid-operation: immediate return to reset values; relock requires a full ARM + LOCK_CNT sequence.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  T1 en=1, mon clock 213 cycles high / 213 low -> period_o=426 with period_vld_o pulses; locked_o=1 on the 4th good period after the arming edge.
//  T2 Locked, then one period of 440 -> fault_o=1, fault_code_o=10, locked_o=0, period_o=440.
//  T3 Locked, then one period of 410 -> fault_code_o=01. Hold clr=0 -> code stays 01 despite later good periods.
//  T4 Locked, mon clock stopped -> fault_code_o=11 exactly TIMEOUT+1 cycles after the last rise; period_vld_o silent.
//  T5 During ACQ: periods 426,426,400,426x4 -> no fault; lock only after the last 4 good periods.
//  T6 rst_n low mid-LOCKED -> all outputs 0 asynchronously. In FAULT, clr pulse -> ARM then relock; en=0 -> IDLE next cycle.

Source files
------------

// File: rtl/clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// clk_freq_monitor
//   Measures the period of a slow divided clock (mon_clk_in) in clk200M_in
//   cycles. Declares lock after LOCK_CNT consecutive in-tolerance periods and
//   raises a sticky fault on an out-of-range period or a stalled clock.
//
// Ports
//   clk200M_in    in   1      system clock, 200 MHz
//   rst_n         in   1      asynchronous, active-low reset
//   en            in   1      monitor enable (level)
//   clr           in   1      1-cycle pulse; clears fault and re-arms
//   mon_clk_in    in   1      monitored clock, asynchronous to clk200M_in
//   period_o      out  CNT_W  last measured period
//   period_vld_o  out  1      1-cycle pulse when period_o updates
//   locked_o      out  1      frequency locked
//   fault_o       out  1      sticky fault flag
//   fault_code_o  out  2      00 none, 01 too short, 10 too long, 11 stall
//
// States
//   S_IDLE   | disabled, counter held at 0
//   S_ARM    | waiting for the first edge to start a measurement
//   S_ACQ    | measuring, counting consecutive good periods
//   S_LOCKED | locked; any bad period or stall faults
//   S_FAULT  | sticky fault, code frozen until clr or en=0
// -----------------------------------------------------------------------------
module clk_freq_monitor #(
    parameter int CNT_W    = 12,
    parameter int EXP_PER  = 426,
    parameter int TOL      = 4,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic             clk200M_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mon_clk_in,
    output logic [CNT_W-1:0] period_o,
    output logic             period_vld_o,
    output logic             locked_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  PER_MIN = CNT_W'(EXP_PER - TOL);
    localparam logic [CNT_W-1:0]  PER_MAX = CNT_W'(EXP_PER + TOL);
    localparam logic [CNT_W-1:0]  TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_N  = GOOD_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACQ,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t            state;
    logic              s1, s2, s3;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good_cnt;

    logic              rise;
    logic              stall;
    logic [CNT_W-1:0]  meas;
    logic              per_short;
    logic              per_long;
    logic              per_good;

    assign rise      = s2 & ~s3;
    assign stall     = (cnt == TO_CNT);
    // cnt is cleared on the edge, so the period is one more than the count;
    // saturate so a long wait in FAULT cannot wrap to a small value.
    assign meas      = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign per_short = (meas < PER_MIN);
    assign per_long  = (meas > PER_MAX);
    assign per_good  = ~per_short & ~per_long;

    always_ff @(posedge clk200M_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            good_cnt     <= '0;
            period_o     <= '0;
            period_vld_o <= 1'b0;
            locked_o     <= 1'b0;
            fault_o      <= 1'b0;
            fault_code_o <= 2'b00;
        end else begin
            s1           <= mon_clk_in;
            s2           <= s1;
            s3           <= s2;
            period_vld_o <= 1'b0;

            if (state == S_IDLE || rise) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (!en) begin
                state        <= S_IDLE;
                good_cnt     <= '0;
                locked_o     <= 1'b0;
                fault_o      <= 1'b0;
                fault_code_o <= 2'b00;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ARM;
                    end
                    S_ARM: begin
                        if (rise) begin
                            state    <= S_ACQ;
                            good_cnt <= '0;
                        end else if (stall) begin
                            state        <= S_FAULT;
                            fault_o      <= 1'b1;
                            locked_o     <= 1'b0;
                            fault_code_o <= 2'b11;
                        end
                    end
                    S_ACQ: begin
                        if (rise) begin
                            period_o     <= meas;
                            period_vld_o <= 1'b1;
                            if (per_good) begin
                                good_cnt <= good_cnt + GOOD_W'(1);
                                if (good_cnt + GOOD_W'(1) == LOCK_N) begin
                                    state    <= S_LOCKED;
                                    locked_o <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end else if (stall) begin
                            state        <= S_FAULT;
                            fault_o      <= 1'b1;
                            locked_o     <= 1'b0;
                            fault_code_o <= 2'b11;
                        end
                    end
                    S_LOCKED: begin
                        if (rise) begin
                            period_o     <= meas;
                            period_vld_o <= 1'b1;
                            if (!per_good) begin
                                state        <= S_FAULT;
                                fault_o      <= 1'b1;
                                locked_o     <= 1'b0;
                                fault_code_o <= per_short ? 2'b01 : 2'b10;
                            end
                        end else if (stall) begin
                            state        <= S_FAULT;
                            fault_o      <= 1'b1;
                            locked_o     <= 1'b0;
                            fault_code_o <= 2'b11;
                        end
                    end
                    S_FAULT: begin
                        if (clr) begin
                            state        <= S_ARM;
                            good_cnt     <= '0;
                            fault_o      <= 1'b0;
                            fault_code_o <= 2'b00;
                        end else if (rise) begin
                            period_o     <= meas;
                            period_vld_o <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_freq_monitor
//   Drives the monitored clock as a list of whole periods (in clk200M_in
//   cycles). Every period_vld_o pulse is captured and compared against either
//   a fixed table or a period-list reference model.
// -----------------------------------------------------------------------------
module tb_clk_freq_monitor;

    localparam int CNT_W    = 12;
    localparam int EXP_PER  = 426;
    localparam int TOL      = 4;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 1023;

    logic             clk200M_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic             mon_clk_in;
    logic [CNT_W-1:0] period_o;
    logic             period_vld_o;
    logic             locked_o;
    logic             fault_o;
    logic [1:0]       fault_code_o;

    clk_freq_monitor #(
        .CNT_W   (CNT_W),
        .EXP_PER (EXP_PER),
        .TOL     (TOL),
        .LOCK_CNT(LOCK_CNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk200M_in  (clk200M_in),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .mon_clk_in  (mon_clk_in),
        .period_o    (period_o),
        .period_vld_o(period_vld_o),
        .locked_o    (locked_o),
        .fault_o     (fault_o),
        .fault_code_o(fault_code_o)
    );

    always #5 clk200M_in = ~clk200M_in;

    typedef struct {
        int grp;
        int per;
        int period;
        bit locked;
        bit fault;
        int code;
    } vec_t;

    vec_t tab[21];
    vec_t obs_q[$];
    vec_t exp_q[$];
    int   stim_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_vld_cyc = 0;

    always @(posedge clk200M_in) cyc <= cyc + 1;

    always @(negedge clk200M_in) begin
        if (rst_n === 1'b1 && period_vld_o === 1'b1) begin
            obs_q.push_back('{0, 0, int'(period_o), locked_o, fault_o, int'(fault_code_o)});
            last_vld_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk200M_in);
        #1;
    endtask

    task automatic drive_period(input int p);
        mon_clk_in = 1'b1;
        repeat (p / 2) tick();
        mon_clk_in = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    // Reference: walk the period list applying the lock/fault rules directly.
    task automatic model();
        int  streak = 0;
        bit  lk = 0;
        bit  flt = 0;
        int  cd = 0;
        bit  good;
        exp_q.delete();
        foreach (stim_q[i]) begin
            good = (stim_q[i] >= EXP_PER - TOL) && (stim_q[i] <= EXP_PER + TOL);
            if (flt) begin
                // frozen until clr / en=0
            end else if (lk) begin
                if (!good) begin
                    flt = 1;
                    lk  = 0;
                    cd  = (stim_q[i] < EXP_PER - TOL) ? 1 : 2;
                end
            end else if (good) begin
                streak++;
                if (streak == LOCK_CNT) lk = 1;
            end else begin
                streak = 0;
            end
            exp_q.push_back('{0, stim_q[i], stim_q[i], lk, flt, cd});
        end
    endtask

    task automatic load_grp(input int g);
        stim_q.delete();
        exp_q.delete();
        foreach (tab[i]) begin
            if (tab[i].grp == g) begin
                stim_q.push_back(tab[i].per);
                exp_q.push_back(tab[i]);
            end
        end
    endtask

    task automatic load_good(input int extra);
        stim_q.delete();
        repeat (LOCK_CNT) stim_q.push_back(EXP_PER);
        if (extra > 0) stim_q.push_back(extra);
        model();
    endtask

    // First rise arms the monitor; each later rise measures the previous period.
    task automatic run_seq(input bit restart, input string name);
        if (restart) begin
            en = 1'b0;
            tick();
            tick();
            en = 1'b1;
            tick();
        end
        obs_q.delete();
        foreach (stim_q[i]) drive_period(stim_q[i]);
        mon_clk_in = 1'b1;
        repeat (6) tick();
        mon_clk_in = 1'b0;
        repeat (4) tick();
        chk({name, " vld count"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            n_vec++;
            if (i >= obs_q.size()) begin
                n_err++;
                $display("FAIL %s[%0d]: no period_vld_o pulse, required period=%0d", name, i, exp_q[i].period);
            end else if (obs_q[i].period != exp_q[i].period || obs_q[i].locked != exp_q[i].locked ||
                         obs_q[i].fault != exp_q[i].fault || obs_q[i].code != exp_q[i].code) begin
                n_err++;
                $display("FAIL %s[%0d]: got period=%0d locked=%0d fault=%0d code=%0d, required period=%0d locked=%0d fault=%0d code=%0d",
                         name, i, obs_q[i].period, obs_q[i].locked, obs_q[i].fault, obs_q[i].code,
                         exp_q[i].period, exp_q[i].locked, exp_q[i].fault, exp_q[i].code);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int fc;
        int n0;
        int p;

        tab = '{
            '{1, 426, 426, 0, 0, 0}, '{1, 426, 426, 0, 0, 0}, '{1, 426, 426, 0, 0, 0},
            '{1, 426, 426, 1, 0, 0}, '{1, 426, 426, 1, 0, 0}, '{1, 440, 440, 0, 1, 2},
            '{1, 426, 426, 0, 1, 2},
            '{2, 426, 426, 0, 0, 0}, '{2, 426, 426, 0, 0, 0}, '{2, 426, 426, 0, 0, 0},
            '{2, 426, 426, 1, 0, 0}, '{2, 410, 410, 0, 1, 1}, '{2, 426, 426, 0, 1, 1},
            '{2, 426, 426, 0, 1, 1},
            '{3, 426, 426, 0, 0, 0}, '{3, 426, 426, 0, 0, 0}, '{3, 400, 400, 0, 0, 0},
            '{3, 426, 426, 0, 0, 0}, '{3, 426, 426, 0, 0, 0}, '{3, 426, 426, 0, 0, 0},
            '{3, 426, 426, 1, 0, 0}
        };

        rst_n      = 1'b0;
        en         = 1'b0;
        clr        = 1'b0;
        mon_clk_in = 1'b0;
        repeat (3) @(posedge clk200M_in);
        @(negedge clk200M_in);
        chk("reset period_o", period_o, 0);
        chk("reset period_vld_o", period_vld_o, 0);
        chk("reset locked_o", locked_o, 0);
        chk("reset fault_o", fault_o, 0);
        chk("reset fault_code_o", fault_code_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven: lock then long fault, lock then short fault, ACQ with a bad period
        load_grp(1);
        run_seq(1, "tab_long");
        load_grp(2);
        run_seq(1, "tab_short");
        load_grp(3);
        run_seq(1, "tab_acq_bad");

        // Stall from LOCKED: code 11 exactly TIMEOUT+1 cycles after the last edge
        load_good(0);
        run_seq(1, "stall_lock");
        n0 = obs_q.size();
        found = 0;
        fc = 0;
        for (int k = 0; k < 1500 && !found; k++) begin
            @(negedge clk200M_in);
            if (fault_code_o == 2'b11) begin
                found = 1;
                fc = cyc;
            end
        end
        chk("stall seen", found, 1);
        chk("stall latency", fc - last_vld_cyc, TIMEOUT + 1);
        chk("stall vld silent", obs_q.size(), n0);
        chk("stall fault_o", fault_o, 1);
        chk("stall locked_o", locked_o, 0);

        // clr while locked is ignored
        load_good(0);
        run_seq(1, "lock_for_clr");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk200M_in);
        chk("clr ignored locked_o", locked_o, 1);
        chk("clr ignored fault_o", fault_o, 0);

        // Asynchronous reset mid-LOCKED, then full relock from ARM
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst period_o", period_o, 0);
        chk("async rst period_vld_o", period_vld_o, 0);
        chk("async rst locked_o", locked_o, 0);
        chk("async rst fault_o", fault_o, 0);
        chk("async rst fault_code_o", fault_code_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        load_good(0);
        run_seq(0, "relock_after_rst");

        // clr in FAULT re-arms and relocks
        load_good(440);
        run_seq(1, "fault_for_clr");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk200M_in);
        chk("clr fault_o", fault_o, 0);
        chk("clr fault_code_o", fault_code_o, 0);
        chk("clr locked_o", locked_o, 0);
        tick();
        load_good(0);
        run_seq(0, "relock_after_clr");

        // en=0 in FAULT clears flags on the next cycle, period_o holds
        load_good(410);
        run_seq(1, "fault_for_en");
        en = 1'b0;
        tick();
        @(negedge clk200M_in);
        chk("en0 fault_o", fault_o, 0);
        chk("en0 fault_code_o", fault_code_o, 0);
        chk("en0 locked_o", locked_o, 0);
        chk("en0 period_o hold", period_o, 410);
        tick();
        en = 1'b1;

        // Randomized period streams against the reference model
        for (int r = 0; r < 4; r++) begin
            stim_q.delete();
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 9) < 7) p = $urandom_range(422, 430);
                else if ($urandom_range(0, 1) == 1) p = $urandom_range(400, 421);
                else p = $urandom_range(431, 460);
                stim_q.push_back(p);
            end
            model();
            run_seq(1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
